// File: rtl/nubus_pkg.sv
// Shared definitions for the NuBus master-path arbiter.
//   arb_state_t : arbitration/ownership FSM states.
//   TMN_*       : decoded two-bit transfer status codes returned with ACK.
package nubus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        LOST,
        WAIT_BUS,
        OWN
    } arb_state_t;

    localparam logic [1:0] TMN_COMPLETE        = 2'b00;
    localparam logic [1:0] TMN_ERROR           = 2'b01;
    localparam logic [1:0] TMN_BUS_TIMEOUT     = 2'b10;
    localparam logic [1:0] TMN_TRY_AGAIN_LATER = 2'b11;

endpackage

// File: rtl/nubus_master_arbiter_if.sv
// Bundle between the arbiter, the internal master sequencers and the
// open-collector RQST/ARB line drivers.
//   master modport : arbiter side (drives grant, rqst_oe, arb_oe, bus_busy, timeout)
//   slave modport  : environment side (drives req, done and the sampled bus lines)
//   req/grant      : NREQ-wide level request / one-hot grant
//   done           : granted master's transaction has been ACKed
//   rqst_in/arb_in/start_in/ack_in : sampled NuBus lines, active-high
//   rqst_oe/arb_oe : pull RQST / ARB[i] low
interface nubus_master_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic            done;
    logic            rqst_in;
    logic [3:0]      arb_in;
    logic            start_in;
    logic            ack_in;
    logic            rqst_oe;
    logic [3:0]      arb_oe;
    logic            bus_busy;
    logic            timeout;

    modport master (
        input  req, done, rqst_in, arb_in, start_in, ack_in,
        output grant, rqst_oe, arb_oe, bus_busy, timeout
    );

    modport slave (
        output req, done, rqst_in, arb_in, start_in, ack_in,
        input  grant, rqst_oe, arb_oe, bus_busy, timeout
    );
endinterface

// File: rtl/nubus_arb_logic.sv
// Combinational NuBus distributed-arbitration drive and win compare.
//   id     : in  slot ID, active-high
//   arb_in : in  sampled wired-OR ARB lines, active-high
//   en     : in  arbiter is contending
//   arb_oe : out pull ARB[i] low
//   win    : out ARB lines settled to our own ID
module nubus_arb_logic (
    input  logic [3:0] id,
    input  logic [3:0] arb_in,
    input  logic       en,
    output logic [3:0] arb_oe,
    output logic       win
);

    logic outranked;

    // Walk from the MSB down. Once a higher line is asserted where our ID has
    // a zero, someone with a higher ID is on the bus and every lower bit we
    // would drive is withdrawn.
    always_comb begin
        outranked = 1'b0;
        arb_oe    = 4'b0000;
        for (int i = 3; i >= 0; i--) begin
            arb_oe[i] = en & id[i] & ~outranked;
            outranked = outranked | (arb_in[i] & ~id[i]);
        end
    end

    assign win = (arb_in == id);

endmodule

// File: rtl/nubus_master_arbiter.sv
// NuBus master bus-ownership controller. Picks one internal requester
// round-robin, runs distributed arbitration for the card, waits for the bus
// to go idle and then grants the bus to the chosen master until it reports
// done or overstays its tenure.
//   nub_clk   : in  NuBus-rate clock
//   nub_reset : in  asynchronous active-high reset
//   id        : in  slot ID, active-high
//   bus       : master modport of nubus_master_arbiter_if
module nubus_master_arbiter
    import nubus_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int ARB_SETTLE  = 2,
    parameter int OWN_TIMEOUT = 255
) (
    input  logic                   nub_clk,
    input  logic                   nub_reset,
    input  logic [3:0]             id,
    nubus_master_arbiter_if.master bus
);

    localparam int SEL_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(ARB_SETTLE - 1);
    localparam logic [CNT_W-1:0] OWN_LAST    = CNT_W'(OWN_TIMEOUT - 1);

    arb_state_t       state, state_next;
    logic [SEL_W-1:0] sel, sel_next;
    logic [SEL_W-1:0] rr_ptr, rr_next;
    logic [SEL_W-1:0] pick, cand;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             fair_ok;
    logic             busy_q;
    logic             timeout_q, timeout_next;
    logic             arb_en;
    logic             win;

    assign arb_en = (state == ARB) || (state == LOST) || (state == WAIT_BUS);

    nubus_arb_logic u_arb_logic (
        .id     (id),
        .arb_in (bus.arb_in),
        .en     (arb_en),
        .arb_oe (bus.arb_oe),
        .win    (win)
    );

    // First requester at or after the round-robin pointer. Scanning downward
    // lets the closest index overwrite farther ones; with NREQ of 1 or 2 the
    // natural SEL_W wrap is the modulo.
    always_comb begin
        pick = rr_ptr;
        cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = rr_ptr + SEL_W'(k);
            if (bus.req[cand]) begin
                pick = cand;
            end
        end
    end

    // Next-state logic for arbitration, bus wait and ownership tenure.
    always_comb begin
        state_next   = state;
        sel_next     = sel;
        rr_next      = rr_ptr;
        cnt_next     = cnt;
        timeout_next = 1'b0;
        unique case (state)
            IDLE: begin
                // Never join an arbitration already in progress.
                if ((|bus.req) && fair_ok && !bus.rqst_in) begin
                    sel_next   = pick;
                    cnt_next   = '0;
                    state_next = ARB;
                end
            end
            ARB: begin
                if (cnt == SETTLE_LAST) begin
                    state_next = win ? WAIT_BUS : LOST;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            LOST: begin
                // START means the winner has taken the bus and left ARB.
                if (bus.start_in) begin
                    cnt_next   = '0;
                    state_next = ARB;
                end
            end
            WAIT_BUS: begin
                if (!busy_q && !bus.start_in) begin
                    if (bus.req[sel]) begin
                        cnt_next   = '0;
                        state_next = OWN;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            OWN: begin
                if (bus.done) begin
                    rr_next    = (sel == SEL_W'(NREQ - 1)) ? '0 : sel + 1'b1;
                    state_next = IDLE;
                end else if (cnt == OWN_LAST) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register plus the fairness flag: a tenure spends our turn until
    // RQST has been seen released.
    always_ff @(posedge nub_clk or posedge nub_reset) begin
        if (nub_reset) begin
            state     <= IDLE;
            sel       <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
            fair_ok   <= 1'b1;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_next;
            sel       <= sel_next;
            rr_ptr    <= rr_next;
            cnt       <= cnt_next;
            timeout_q <= timeout_next;
            if ((state != OWN) && (state_next == OWN)) begin
                fair_ok <= 1'b0;
            end else if (!bus.rqst_in) begin
                fair_ok <= 1'b1;
            end
        end
    end

    // Bus-busy tracker; START with ACK is an attention cycle and holds state.
    always_ff @(posedge nub_clk or posedge nub_reset) begin
        if (nub_reset) begin
            busy_q <= 1'b0;
        end else if (bus.start_in && !bus.ack_in) begin
            busy_q <= 1'b1;
        end else if (bus.ack_in && !bus.start_in) begin
            busy_q <= 1'b0;
        end
    end

    always_comb begin
        bus.grant = '0;
        if (state == OWN) begin
            bus.grant[sel] = 1'b1;
        end
    end

    assign bus.rqst_oe  = arb_en;
    assign bus.bus_busy = busy_q;
    assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_nubus_master_arbiter.sv
// Directed bench for nubus_master_arbiter. Inputs are driven and outputs are
// sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_nubus_master_arbiter;

    logic       nub_clk = 1'b0;
    logic       nub_reset;
    logic [3:0] id;
    int         compared   = 0;
    int         mismatched = 0;

    nubus_master_arbiter_if #(.NREQ(2)) bus ();

    nubus_master_arbiter #(
        .NREQ        (2),
        .ARB_SETTLE  (2),
        .OWN_TIMEOUT (8)
    ) dut (
        .nub_clk   (nub_clk),
        .nub_reset (nub_reset),
        .id        (id),
        .bus       (bus)
    );

    always #5 nub_clk = ~nub_clk;

    typedef struct {
        logic [3:0] id;
        logic [3:0] arb_in;
        logic [3:0] exp_arb_oe;
    } arb_vec_t;

    typedef struct {
        logic start_in;
        logic ack_in;
        logic exp_busy;
    } busy_vec_t;

    arb_vec_t  arb_vecs[9];
    busy_vec_t busy_vecs[8];

    task automatic tick();
        @(negedge nub_clk);
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] req, input logic [3:0] arb_in);
        bus.req    = req;
        bus.arb_in = arb_in;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int grant_cycles;
        int timeout_cycles;

        arb_vecs[0] = '{4'hC, 4'hD, 4'hC};
        arb_vecs[1] = '{4'h5, 4'hF, 4'h0};
        arb_vecs[2] = '{4'h5, 4'h5, 4'h5};
        arb_vecs[3] = '{4'h5, 4'h7, 4'h4};
        arb_vecs[4] = '{4'h9, 4'hD, 4'h8};
        arb_vecs[5] = '{4'hA, 4'hB, 4'hA};
        arb_vecs[6] = '{4'h3, 4'h7, 4'h0};
        arb_vecs[7] = '{4'hF, 4'h0, 4'hF};
        arb_vecs[8] = '{4'h6, 4'h8, 4'h0};

        busy_vecs[0] = '{1'b1, 1'b0, 1'b1};
        busy_vecs[1] = '{1'b0, 1'b0, 1'b1};
        busy_vecs[2] = '{1'b1, 1'b1, 1'b1};
        busy_vecs[3] = '{1'b0, 1'b1, 1'b0};
        busy_vecs[4] = '{1'b1, 1'b1, 1'b0};
        busy_vecs[5] = '{1'b0, 1'b0, 1'b0};
        busy_vecs[6] = '{1'b1, 1'b0, 1'b1};
        busy_vecs[7] = '{1'b0, 1'b1, 1'b0};

        nub_reset    = 1'b1;
        id           = 4'hC;
        bus.req      = 2'b00;
        bus.done     = 1'b0;
        bus.rqst_in  = 1'b0;
        bus.arb_in   = 4'h0;
        bus.start_in = 1'b0;
        bus.ack_in   = 1'b0;

        // Reset values
        repeat (3) tick();
        check_output("reset_grant",    32'(bus.grant),    32'h0);
        check_output("reset_rqst_oe",  32'(bus.rqst_oe),  32'h0);
        check_output("reset_arb_oe",   32'(bus.arb_oe),   32'h0);
        check_output("reset_bus_busy", 32'(bus.bus_busy), 32'h0);
        check_output("reset_timeout",  32'(bus.timeout),  32'h0);
        nub_reset = 1'b0;
        tick();

        // Uncontested arbitration and tenure
        $display("[TB] uncontested");
        apply_stimulus(2'b01, 4'hC);
        tick();
        check_output("unc_rqst_oe", 32'(bus.rqst_oe), 32'h1);
        check_output("unc_arb_oe",  32'(bus.arb_oe),  32'hC);
        check_output("unc_grant_c1", 32'(bus.grant),  32'h0);
        tick();
        check_output("unc_grant_c2", 32'(bus.grant),  32'h0);
        tick();
        check_output("unc_grant_c3", 32'(bus.grant),  32'h0);
        tick();
        check_output("unc_grant",      32'(bus.grant),   32'h1);
        check_output("unc_rqst_drop",  32'(bus.rqst_oe), 32'h0);
        check_output("unc_arb_drop",   32'(bus.arb_oe),  32'h0);
        bus.start_in = 1'b1;
        tick();
        check_output("unc_busy_set",   32'(bus.bus_busy), 32'h1);
        check_output("unc_grant_hold", 32'(bus.grant),    32'h1);
        bus.start_in = 1'b0;
        bus.ack_in   = 1'b1;
        bus.done     = 1'b1;
        bus.req      = 2'b00;
        tick();
        check_output("unc_done_grant", 32'(bus.grant),    32'h0);
        check_output("unc_done_busy",  32'(bus.bus_busy), 32'h0);
        check_output("unc_done_idle",  32'(bus.rqst_oe),  32'h0);
        bus.ack_in = 1'b0;
        bus.done   = 1'b0;
        bus.arb_in = 4'h0;
        tick();

        // Lost arbitration, withdrawal table, re-arbitration after START
        $display("[TB] lost arbitration");
        apply_stimulus(2'b01, 4'hD);
        repeat (3) tick();
        check_output("lost_rqst_oe", 32'(bus.rqst_oe), 32'h1);
        check_output("lost_arb_oe",  32'(bus.arb_oe),  32'hC);
        check_output("lost_grant",   32'(bus.grant),   32'h0);
        for (int v = 0; v < 9; v++) begin
            id         = arb_vecs[v].id;
            bus.arb_in = arb_vecs[v].arb_in;
            #1;
            check_output($sformatf("arb_vec%0d", v), 32'(bus.arb_oe),
                         32'(arb_vecs[v].exp_arb_oe));
            tick();
        end
        id         = 4'hC;
        bus.arb_in = 4'hD;
        bus.done   = 1'b1;
        tick();
        bus.done = 1'b0;
        tick();
        check_output("lost_done_ignored", 32'(bus.grant),   32'h0);
        check_output("lost_still_rqst",   32'(bus.rqst_oe), 32'h1);
        bus.start_in = 1'b1;
        bus.arb_in   = 4'hC;
        tick();
        check_output("rearb_busy",  32'(bus.bus_busy), 32'h1);
        check_output("rearb_rqst",  32'(bus.rqst_oe),  32'h1);
        check_output("rearb_g1",    32'(bus.grant),    32'h0);
        bus.start_in = 1'b0;
        bus.ack_in   = 1'b1;
        tick();
        check_output("rearb_unbusy", 32'(bus.bus_busy), 32'h0);
        check_output("rearb_g2",     32'(bus.grant),    32'h0);
        bus.ack_in = 1'b0;
        tick();
        check_output("rearb_g3",     32'(bus.grant),    32'h0);
        tick();
        check_output("rearb_grant",  32'(bus.grant),    32'h1);
        bus.done = 1'b1;
        bus.req  = 2'b00;
        tick();
        check_output("rearb_release", 32'(bus.grant), 32'h0);
        bus.done   = 1'b0;
        bus.arb_in = 4'h0;

        // Win while the bus is busy
        $display("[TB] busy bus");
        bus.start_in = 1'b1;
        tick();
        check_output("busy_set", 32'(bus.bus_busy), 32'h1);
        bus.ack_in = 1'b1;
        tick();
        check_output("attention_holds", 32'(bus.bus_busy), 32'h1);
        bus.start_in = 1'b0;
        bus.ack_in   = 1'b0;
        apply_stimulus(2'b01, 4'hC);
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            check_output("busy_hold_grant", 32'(bus.grant),   32'h0);
            check_output("busy_hold_rqst",  32'(bus.rqst_oe), 32'h1);
        end
        bus.ack_in = 1'b1;
        tick();
        check_output("ack_cycle_busy",  32'(bus.bus_busy), 32'h0);
        check_output("ack_cycle_grant", 32'(bus.grant),    32'h0);
        bus.ack_in = 1'b0;
        tick();
        check_output("busy_grant", 32'(bus.grant), 32'h1);
        bus.done = 1'b1;
        bus.req  = 2'b00;
        tick();
        check_output("busy_release", 32'(bus.grant), 32'h0);
        bus.done   = 1'b0;
        bus.arb_in = 4'h0;

        // bus_busy tracking table
        $display("[TB] bus_busy table");
        for (int v = 0; v < 8; v++) begin
            bus.start_in = busy_vecs[v].start_in;
            bus.ack_in   = busy_vecs[v].ack_in;
            tick();
            check_output($sformatf("busy_vec%0d", v), 32'(bus.bus_busy),
                         32'(busy_vecs[v].exp_busy));
        end
        bus.start_in = 1'b0;
        bus.ack_in   = 1'b0;
        tick();

        // Asynchronous reset during ARB and during OWN
        $display("[TB] async reset");
        apply_stimulus(2'b01, 4'hC);
        tick();
        check_output("rst_pre_rqst", 32'(bus.rqst_oe), 32'h1);
        #2;
        nub_reset = 1'b1;
        #1;
        check_output("rst_arb_rqst",  32'(bus.rqst_oe), 32'h0);
        check_output("rst_arb_arboe", 32'(bus.arb_oe),  32'h0);
        check_output("rst_arb_grant", 32'(bus.grant),   32'h0);
        tick();
        nub_reset = 1'b0;
        repeat (4) tick();
        check_output("rst_pre_grant", 32'(bus.grant), 32'h1);
        #2;
        nub_reset = 1'b1;
        #1;
        check_output("rst_own_grant", 32'(bus.grant), 32'h0);
        bus.req = 2'b00;
        tick();
        nub_reset = 1'b0;

        // Round-robin with fairness
        $display("[TB] round robin");
        apply_stimulus(2'b11, 4'hC);
        tick();
        bus.rqst_in = 1'b1;
        repeat (3) tick();
        check_output("rr_first", 32'(bus.grant), 32'h1);
        bus.done = 1'b1;
        tick();
        check_output("rr_first_release", 32'(bus.grant), 32'h0);
        bus.done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_output("fair_wait", 32'(bus.rqst_oe), 32'h0);
        end
        bus.rqst_in = 1'b0;
        tick();
        check_output("fair_sample", 32'(bus.rqst_oe), 32'h0);
        tick();
        check_output("fair_resume", 32'(bus.rqst_oe), 32'h1);
        repeat (3) tick();
        check_output("rr_second", 32'(bus.grant), 32'h2);
        bus.done = 1'b1;
        tick();
        check_output("rr_second_release", 32'(bus.grant), 32'h0);
        bus.done = 1'b0;
        repeat (4) tick();
        check_output("rr_third", 32'(bus.grant), 32'h1);
        bus.done = 1'b1;
        bus.req  = 2'b00;
        tick();
        bus.done = 1'b0;
        tick();

        // Ownership timeout
        $display("[TB] timeout");
        apply_stimulus(2'b01, 4'hC);
        repeat (4) tick();
        check_output("to_grant", 32'(bus.grant), 32'h1);
        grant_cycles   = 1;
        timeout_cycles = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (bus.grant != 2'b00) grant_cycles++;
            if (bus.timeout) begin
                timeout_cycles++;
                if (timeout_cycles == 1) begin
                    check_output("to_pulse_grant", 32'(bus.grant),   32'h0);
                    check_output("to_pulse_idle",  32'(bus.rqst_oe), 32'h0);
                end
                bus.req = 2'b00;
            end
        end
        check_output("to_grant_cycles",   32'(grant_cycles),   32'd8);
        check_output("to_timeout_cycles", 32'(timeout_cycles), 32'd1);
        check_output("to_end_idle",       32'(bus.rqst_oe),    32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
